aviasales_top: RTL and testbench

Seat-booking controller for a 16-flight ticket office on a 50 MHz FPGA board. It keeps a sold-seat counter per flight and takes book/cancel requests from an on-board button and two external PMOD lines. It shows the selected flight and its sold count on a 4-digit multiplexed 7-segment display, and exports seats-remaining and event strobes on PMOD headers JB/JC.

---
 rtl/aviasales_top.sv | 200 ++++++++++++++++++++
 tb/tb_aviasales_top.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aviasales_top.sv
// Seat-booking controller: per-flight sold counters, book/cancel strobes, 7-seg status display.
// Optional input debounce is enabled with `define AVIASALES_DEBOUNCE_EN.
module aviasales_top #(
  parameter int CAPACITY      = 99,
  parameter int SCAN_BITS     = 16,
  parameter int DEBOUNCE_BITS = 18
) (
  input  logic       clk,
  input  logic       BTN3,
  input  logic       BTN0,
  input  logic       JA1,
  input  logic       JA7,
  input  logic [3:0] SW,
  output logic       LED0,
  output logic [6:0] seg,
  output logic       seg_P,
  output logic [3:0] AN,
  output logic       JB9,
  output logic       JB8,
  output logic       JB7,
  output logic       JB4,
  output logic       JB3,
  output logic       JB2,
  output logic       JB1,
  output logic       JC1,
  output logic       JC2,
  output logic       JC4
);

  logic                 rst;
  logic [1:0]           b_sy, a_sy, c_sy;
  logic [3:0]           sw_s1, f;
  logic [2:0]           raw, lvl, prev, edges;
  logic                 ev_book, ev_cancel;
  logic [6:0]           sold [16];
  logic [6:0]           cur;
  logic [6:0]           jb_q;
  logic                 led_q, jc1_q, jc2_q, jc4_q;
  logic [SCAN_BITS+1:0] scan;
  logic [1:0]           sel;
  logic [3:0]           s_tens, s_units, f_tens, f_units, digit;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q;
  logic                 dp_q;

  assign rst = BTN3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_sy  <= '0;
      a_sy  <= '0;
      c_sy  <= '0;
      sw_s1 <= '0;
      f     <= '0;
    end else begin
      b_sy  <= {b_sy[0], BTN0};
      a_sy  <= {a_sy[0], JA1};
      c_sy  <= {c_sy[0], JA7};
      sw_s1 <= SW;
      f     <= sw_s1;
    end
  end

  assign raw = {c_sy[1], a_sy[1], b_sy[1]};

`ifdef AVIASALES_DEBOUNCE_EN
  logic [DEBOUNCE_BITS-1:0] dcnt [3];

  // Level flips only after 2^DEBOUNCE_BITS consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= '0;
      for (int unsigned i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (raw[i] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == '1) begin
          lvl[i]  <= raw[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign lvl = raw;
`endif

  assign edges = lvl & ~prev;
  assign cur   = sold[f];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      ev_book   <= 1'b0;
      ev_cancel <= 1'b0;
    end else begin
      prev      <= lvl;
      ev_book   <= edges[0] | edges[1];
      ev_cancel <= edges[2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) sold[i] <= '0;
      jc1_q <= 1'b0;
      jc2_q <= 1'b0;
      jc4_q <= 1'b0;
    end else begin
      jc1_q <= 1'b0;
      jc2_q <= 1'b0;
      jc4_q <= 1'b0;
      if (ev_book && ev_cancel) begin
        jc1_q <= 1'b1;
        jc4_q <= 1'b1;
      end else if (ev_book) begin
        if (cur < 7'(CAPACITY)) begin
          sold[f] <= cur + 7'd1;
          jc1_q   <= 1'b1;
        end else begin
          jc2_q   <= 1'b1;
        end
      end else if (ev_cancel && cur != 7'd0) begin
        sold[f] <= cur - 7'd1;
        jc4_q   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 1'b0;
      jb_q  <= 7'(CAPACITY);
    end else begin
      led_q <= (cur == 7'(CAPACITY));
      jb_q  <= 7'(CAPACITY) - cur;
    end
  end

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = ~7'h3F;
      4'd1:    dec7 = ~7'h06;
      4'd2:    dec7 = ~7'h5B;
      4'd3:    dec7 = ~7'h4F;
      4'd4:    dec7 = ~7'h66;
      4'd5:    dec7 = ~7'h6D;
      4'd6:    dec7 = ~7'h7D;
      4'd7:    dec7 = ~7'h07;
      4'd8:    dec7 = ~7'h7F;
      4'd9:    dec7 = ~7'h6F;
      default: dec7 = '1;
    endcase
  endfunction

  assign sel = scan[SCAN_BITS+1 -: 2];

  always_comb begin
    s_tens = '0;
    for (int unsigned k = 1; k < 10; k++) begin
      if (cur >= 7'(k * 10)) s_tens = 4'(k);
    end
    s_units = 4'(cur - 7'(s_tens * 4'd10));
    f_tens  = (f >= 4'd10) ? 4'd1 : 4'd0;
    f_units = (f >= 4'd10) ? f - 4'd10 : f;
    case (sel)
      2'd0:    begin digit = s_units; an_d = 4'b1110; end
      2'd1:    begin digit = s_tens;  an_d = 4'b1101; end
      2'd2:    begin digit = f_units; an_d = 4'b1011; end
      default: begin digit = f_tens;  an_d = 4'b0111; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan  <= '0;
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
    end else begin
      scan  <= scan + 1'b1;
      an_q  <= an_d;
      seg_q <= dec7(digit);
      dp_q  <= (sel != 2'd2);
    end
  end

  assign LED0  = led_q;
  assign AN    = an_q;
  assign seg   = seg_q;
  assign seg_P = dp_q;
  assign JC1   = jc1_q;
  assign JC2   = jc2_q;
  assign JC4   = jc4_q;
  assign {JB9, JB8, JB7, JB4, JB3, JB2, JB1} = jb_q;

endmodule

// File: tb/tb_aviasales_top.sv
// Directed self-checking bench for aviasales_top (short scan prescaler, no debounce).
module tb_aviasales_top;

  localparam int SB = 4;

  logic       clk = 1'b0;
  logic       BTN3, BTN0, JA1, JA7;
  logic [3:0] SW;
  logic       LED0, seg_P, JB9, JB8, JB7, JB4, JB3, JB2, JB1, JC1, JC2, JC4;
  logic [6:0] seg;
  logic [3:0] AN;
  logic [6:0] jb;

  int compared = 0;
  int mismatched = 0;
  int c1 = 0, c2 = 0, c4 = 0, wide = 0;
  logic l1 = 1'b0, l2 = 1'b0, l4 = 1'b0;
  int b1, b2, b4, k;

  aviasales_top #(.CAPACITY(99), .SCAN_BITS(SB), .DEBOUNCE_BITS(18)) dut (
    .clk(clk), .BTN3(BTN3), .BTN0(BTN0), .JA1(JA1), .JA7(JA7), .SW(SW),
    .LED0(LED0), .seg(seg), .seg_P(seg_P), .AN(AN),
    .JB9(JB9), .JB8(JB8), .JB7(JB7), .JB4(JB4), .JB3(JB3), .JB2(JB2), .JB1(JB1),
    .JC1(JC1), .JC2(JC2), .JC4(JC4)
  );

  always #10 clk = ~clk;

  assign jb = {JB9, JB8, JB7, JB4, JB3, JB2, JB1};

  // Strobe pulse counters plus a check that no strobe lasts two cycles.
  always @(negedge clk) begin
    if (JC1) c1 <= c1 + 1;
    if (JC2) c2 <= c2 + 1;
    if (JC4) c4 <= c4 + 1;
    if ((JC1 && l1) || (JC2 && l2) || (JC4 && l4)) wide <= wide + 1;
    l1 <= JC1;
    l2 <= JC2;
    l4 <= JC4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bit0 = BTN0, bit1 = JA1, bit2 = JA7
  task automatic pulse(input logic [2:0] mask);
    @(negedge clk);
    BTN0 = mask[0]; JA1 = mask[1]; JA7 = mask[2];
    cycles(4);
    BTN0 = 1'b0; JA1 = 1'b0; JA7 = 1'b0;
    cycles(8);
  endtask

  task automatic disp(input string tag, input logic [3:0] an, input logic [6:0] s, input logic dp);
    int n;
    n = 0;
    while (AN !== an && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_an"}, AN, an);
    chk({tag, "_seg"}, seg, s);
    chk({tag, "_dp"}, seg_P, dp);
  endtask

  initial begin
    BTN3 = 1'b1; BTN0 = 1'b0; JA1 = 1'b0; JA7 = 1'b0; SW = 4'd0;

    // Reset state
    cycles(50);
    chk("rst_an", AN, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", seg_P, 1'b1);
    chk("rst_led", LED0, 1'b0);
    chk("rst_jb", jb, 7'd99);
    chk("rst_jc", {JC1, JC2, JC4}, 3'b000);
    BTN3 = 1'b0;
    @(negedge clk);
    chk("scan_first", AN, 4'b1110);
    k = 1;
    while (AN === 4'b1110 && k < 100) begin
      @(negedge clk);
      if (AN === 4'b1110) k++;
    end
    chk("scan_dwell", k, 1 << SB);
    chk("scan_an1", AN, 4'b1101);
    cycles(1 << SB);
    chk("scan_an2", AN, 4'b1011);
    cycles(1 << SB);
    chk("scan_an3", AN, 4'b0111);

    // Single booking on flight 3 with exact latency
    SW = 4'd3;
    cycles(6);
    b1 = c1; b2 = c2;
    @(negedge clk);
    BTN0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("lat_jc1_early", JC1, 1'b0);
    @(posedge clk);
    #1 chk("lat_jc1_n3", JC1, 1'b1);
    chk("lat_jb_n3", jb, 7'd99);
    @(posedge clk);
    #1 chk("lat_jc1_n4", JC1, 1'b0);
    chk("lat_jb_n4", jb, 7'd98);
    cycles(20);
    BTN0 = 1'b0;
    cycles(6);
    chk("b3_jc1_cnt", c1 - b1, 1);
    chk("b3_jc2_cnt", c2 - b2, 0);
    chk("b3_led", LED0, 1'b0);
    disp("d3_ft", 4'b0111, 7'h40, 1'b1);
    disp("d3_fu", 4'b1011, 7'h30, 1'b0);
    disp("d3_st", 4'b1101, 7'h40, 1'b1);
    disp("d3_su", 4'b1110, 7'h79, 1'b1);

    // Fill flight 5, then one over-capacity request
    SW = 4'd5;
    cycles(6);
    chk("f5_jb_init", jb, 7'd99);
    b1 = c1; b2 = c2;
    for (int i = 0; i < 99; i++) pulse(3'b010);
    chk("f5_jc1_99", c1 - b1, 99);
    chk("f5_jc2_99", c2 - b2, 0);
    chk("f5_led_full", LED0, 1'b1);
    pulse(3'b010);
    chk("f5_jc1_100", c1 - b1, 99);
    chk("f5_jc2_100", c2 - b2, 1);
    chk("f5_jb", jb, 7'd0);
    chk("f5_led", LED0, 1'b1);
    disp("d5_fu", 4'b1011, 7'h12, 1'b0);
    disp("d5_st", 4'b1101, 7'h10, 1'b1);
    disp("d5_su", 4'b1110, 7'h10, 1'b1);

    // Flight 7: cancel at zero is ignored, then book twice and cancel once
    SW = 4'd7;
    cycles(6);
    b1 = c1; b4 = c4;
    pulse(3'b100);
    chk("f7_c0_jc4", c4 - b4, 0);
    chk("f7_c0_jb", jb, 7'd99);
    pulse(3'b001);
    pulse(3'b001);
    chk("f7_jb2", jb, 7'd97);
    pulse(3'b100);
    chk("f7_jc4", c4 - b4, 1);
    chk("f7_jc1", c1 - b1, 2);
    chk("f7_jb1", jb, 7'd98);

    // Simultaneous book and cancel leaves the count alone but pulses both
    b1 = c1; b2 = c2; b4 = c4;
    pulse(3'b101);
    chk("sim_jc1", c1 - b1, 1);
    chk("sim_jc4", c4 - b4, 1);
    chk("sim_jc2", c2 - b2, 0);
    chk("sim_jb", jb, 7'd98);

    // Simultaneous BTN0 and JA1 count as one booking
    SW = 4'd9;
    cycles(6);
    b1 = c1;
    pulse(3'b011);
    chk("dual_jc1", c1 - b1, 1);
    chk("dual_jb", jb, 7'd98);

    // Flight switch does not touch counts
    SW = 4'd3;
    cycles(6);
    chk("sw3_jb", jb, 7'd98);
    chk("sw3_led", LED0, 1'b0);
    disp("e3_fu", 4'b1011, 7'h30, 1'b0);
    disp("e3_su", 4'b1110, 7'h79, 1'b1);
    chk("strobe_width", wide, 0);

    // Reset clears every flight
    @(negedge clk);
    BTN3 = 1'b1;
    cycles(3);
    chk("rst2_an", AN, 4'b1111);
    chk("rst2_jb", jb, 7'd99);
    BTN3 = 1'b0;
    for (int s = 0; s < 16; s++) begin
      SW = 4'(s);
      cycles(5);
      chk("rst2_sw_jb", jb, 7'd99);
      chk("rst2_sw_led", LED0, 1'b0);
    end
    disp("d15_ft", 4'b0111, 7'h79, 1'b1);
    disp("d15_fu", 4'b1011, 7'h12, 1'b0);
    disp("d15_st", 4'b1101, 7'h40, 1'b1);
    disp("d15_su", 4'b1110, 7'h40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
